mmcm_rst_seq: RTL and testbench
===============================

MMCM_RST_SEQ -- requirements
Module: mmcm_rst_seq

Interface
REQ-001 Parameter RST_CYCLES, default 100: number of cycles mmcm_rst is held high per reset attempt (range 1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 4096: number of WAIT_LOCK cycles without lock before the attempt is declared failed (range 1..65535).
REQ-003 Parameter SETTLE_CYCLES, default 64: number of consecutive locked cycles required before clk_ready asserts (range 1..65535).
REQ-004 Parameter MAX_RETRY, default 3: number of timeout retries before FAULT (range 0..15).
REQ-005 clk  input  1  sequencer clock; a free-running reference clock, not an MMCM output.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sw_rst_req  input  1  single-cycle software request to restart the MMCM sequence.
REQ-008 mmcm_locked  input  1  MMCM LOCKED signal, asynchronous to clk.
REQ-009 mmcm_rst  output  1  registered reset to the MMCM RST pin.
REQ-010 clk_ready  output  1  registered flag: MMCM output clocks are usable.
REQ-011 fault  output  1  registered flag: retries exhausted.
REQ-012 retry_cnt  output  4  timeout retries in the current sequence.
REQ-013 lock_loss_cnt  output  8  count of lock losses while in READY; saturates at 255.
REQ-014 state  output  3  current state encoding: ASSERT=0, WAIT_LOCK=1, SETTLE=2, READY=3, FAULT=4.

Function
REQ-015 mmcm_locked SHALL pass through a 2-flop synchronizer to locked_s; latency is 2 cycles; both flops reset to 0.
REQ-016 A single 16-bit cycle counter SHALL clear on every state transition and increment once per cycle within a state.
REQ-017 ASSERT: mmcm_rst=1; when the counter reaches RST_CYCLES-1, the block SHALL go to WAIT_LOCK, so mmcm_rst is high for exactly RST_CYCLES cycles.
REQ-018 WAIT_LOCK: if locked_s=1, the block SHALL go to SETTLE. Otherwise, when the counter reaches LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY, go to FAULT; else increment retry_cnt and go to ASSERT.
REQ-019 SETTLE: if locked_s=0, the block SHALL go to ASSERT with retry_cnt unchanged. When the counter reaches SETTLE_CYCLES-1 with locked_s=1, go to READY and clear retry_cnt.
REQ-020 READY: clk_ready=1; if locked_s=0, the block SHALL increment lock_loss_cnt (saturating at 255) and go to ASSERT.
REQ-021 FAULT: fault=1, mmcm_rst=0, clk_ready=0; the block SHALL remain in FAULT until sw_rst_req or reset.
REQ-022 sw_rst_req=1 in any state SHALL force ASSERT next cycle, clear the counter, clear retry_cnt and clear fault; this has priority over every other transition.
REQ-023 sw_rst_req and a lock loss in READY in the same cycle: go to ASSERT and still increment lock_loss_cnt.
REQ-024 mmcm_rst, clk_ready and fault SHALL be decoded from the next state and registered, so they change in the same cycle as state.
REQ-025 The counter SHALL NOT wrap; terminal-count compares guarantee exit before 2^16.

Reset
REQ-026 While reset=1 (synchronous), the block SHALL set state=ASSERT, counter=0, mmcm_rst=1, clk_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, and both synchronizer flops to 0.
REQ-027 Reset asserted mid-sequence SHALL override sw_rst_req and all transitions; the first cycle after release is ASSERT cycle 0.

Verification (bench parameters RST_CYCLES=4, LOCK_TIMEOUT=16, SETTLE_CYCLES=8, MAX_RETRY=2)
REQ-028 Normal bring-up: release reset, raise mmcm_locked 10 cycles later -> mmcm_rst high for exactly 4 cycles; clk_ready rises 2+8 cycles after the locked edge (plus 1 for the SETTLE entry); retry_cnt=0.
REQ-029 Never lock: hold mmcm_locked=0 -> three mmcm_rst pulses of 4 cycles each, retry_cnt goes 1 then 2, then fault=1 and state=4 after the third 16-cycle wait; mmcm_rst stays 0 thereafter.
REQ-030 Lock glitch in SETTLE: drop mmcm_locked for 3 cycles at SETTLE count 5 -> return to ASSERT, retry_cnt unchanged, clk_ready stays 0.
REQ-031 Lock loss in READY, repeated 257 times -> lock_loss_cnt saturates at 255; each loss produces a new 4-cycle mmcm_rst pulse.
REQ-032 Pulse sw_rst_req while in FAULT -> fault=0, retry_cnt=0 and state=0 next cycle; pulse it together with a lock loss in READY -> ASSERT and lock_loss_cnt+1.
REQ-033 Assert reset during WAIT_LOCK count 7 -> all outputs return to their REQ-026 values; the sequence restarts cleanly after release.

Source files
------------

// File: rtl/mmcm_rst_seq.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for LOCKED, requires a
// stable settle window before declaring the output clocks usable, retries on
// lock timeout and parks in FAULT once the retry budget is spent.
module mmcm_rst_seq #(
  parameter int unsigned RST_CYCLES    = 100,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sw_rst_req_i,
  input  logic       mmcm_locked_i,
  output logic       mmcm_rst_o,
  output logic       clk_ready_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // Terminal counts, pre-sized to the counter width.
  localparam logic [15:0] RST_TC    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_TC   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_TC = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  logic        sync1_q;
  logic        sync2_q;
  logic        locked_s;
  state_e      state_q;
  state_e      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] cnt_inc_s;
  logic [3:0]  retry_q;
  logic [3:0]  retry_d;
  logic [7:0]  loss_q;
  logic [7:0]  loss_d;
  logic        mmcm_rst_q;
  logic        clk_ready_q;
  logic        fault_q;

  assign locked_s = sync2_q;

  // Two-flop synchronizer bringing the asynchronous LOCKED into clk domain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= mmcm_locked_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter, retry and lock-loss bookkeeping.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    cnt_d     = cnt_q;
    // Counter holds at all-ones in states that have no terminal count.
    cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);

    // A lock loss in READY is always counted, even if software restarts too.
    if ((state_q == ST_READY) && !locked_s) begin
      loss_d = (loss_q == 8'hFF) ? loss_q : (loss_q + 8'd1);
    end else begin
      loss_d = loss_q;
    end

    if (sw_rst_req_i) begin
      state_d = ST_ASSERT;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == RST_TC) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_ASSERT;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == LOCK_TC) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_ASSERT;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_SETTLE: begin
          if (!locked_s) begin
            state_d = ST_ASSERT;
          end else if (cnt_q == SETTLE_TC) begin
            state_d = ST_READY;
            retry_d = 4'd0;
          end else begin
            state_d = ST_SETTLE;
          end
        end
        ST_READY: begin
          if (!locked_s) begin
            state_d = ST_ASSERT;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          // Illegal encodings recover through a fresh reset pulse.
          state_d = ST_ASSERT;
        end
      endcase
    end

    // Counter restarts on every transition and on a software restart.
    if (sw_rst_req_i || (state_d != state_q)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_inc_s;
    end
  end

  // State register with outputs decoded from the next state so they align.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= 16'd0;
      retry_q     <= 4'd0;
      loss_q      <= 8'd0;
      mmcm_rst_q  <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      mmcm_rst_q  <= (state_d == ST_ASSERT);
      clk_ready_q <= (state_d == ST_READY);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign mmcm_rst_o      = mmcm_rst_q;
  assign clk_ready_o     = clk_ready_q;
  assign fault_o         = fault_q;
  assign retry_cnt_o     = retry_q;
  assign lock_loss_cnt_o = loss_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_mmcm_rst_seq.sv
// Self-checking bench for mmcm_rst_seq: a short vector table, directed
// multi-cycle sequences and randomized traffic, all against a reference model
// built on "cycles remaining in phase" rather than an up-counter.
module tb_mmcm_rst_seq;
  localparam int RC = 4;
  localparam int LT = 16;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int S_ASSERT = 0;
  localparam int S_WAIT   = 1;
  localparam int S_SETTLE = 2;
  localparam int S_READY  = 3;
  localparam int S_FAULT  = 4;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       sw_rst_req_i = 1'b0;
  logic       mmcm_locked_i = 1'b0;
  logic       mmcm_rst_o;
  logic       clk_ready_o;
  logic       fault_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  mmcm_rst_seq #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .MAX_RETRY(MR)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .sw_rst_req_i(sw_rst_req_i),
    .mmcm_locked_i(mmcm_locked_i), .mmcm_rst_o(mmcm_rst_o),
    .clk_ready_o(clk_ready_o), .fault_o(fault_o), .retry_cnt_o(retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o), .state_o(state_o)
  );

  int total = 0;
  int bad = 0;

  // Reference model
  int m_st = S_ASSERT;
  int m_left = RC;
  int m_retry = 0;
  int m_loss = 0;
  bit m_h0 = 1'b0;
  bit m_h1 = 1'b0;

  task automatic m_enter(input int s);
    m_st = s;
    case (s)
      S_ASSERT: m_left = RC;
      S_WAIT:   m_left = LT;
      S_SETTLE: m_left = SC;
      default:  m_left = 0;
    endcase
  endtask

  task automatic m_update(input bit r, input bit s, input bit l);
    bit ls;
    ls = m_h1;       // LOCKED as seen two sampling edges ago
    m_h1 = m_h0;
    m_h0 = l;
    if (r) begin
      m_h0 = 1'b0; m_h1 = 1'b0; m_retry = 0; m_loss = 0;
      m_enter(S_ASSERT);
      return;
    end
    if (m_st == S_READY && !ls && m_loss < 255) m_loss++;
    if (s) begin
      m_retry = 0;
      m_enter(S_ASSERT);
      return;
    end
    case (m_st)
      S_ASSERT: begin
        m_left--;
        if (m_left == 0) m_enter(S_WAIT);
      end
      S_WAIT: begin
        if (ls) m_enter(S_SETTLE);
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_retry == MR) m_enter(S_FAULT);
            else begin m_retry++; m_enter(S_ASSERT); end
          end
        end
      end
      S_SETTLE: begin
        if (!ls) m_enter(S_ASSERT);
        else begin
          m_left--;
          if (m_left == 0) begin m_retry = 0; m_enter(S_READY); end
        end
      end
      S_READY: if (!ls) m_enter(S_ASSERT);
      default: ;
    endcase
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit s, input bit l);
    int es, er, ey, ef;
    reset_i = r; sw_rst_req_i = s; mmcm_locked_i = l;
    m_update(r, s, l);
    @(posedge clk);
    #1;
    es = m_st;
    er = (m_st == S_ASSERT) ? 1 : 0;
    ey = (m_st == S_READY) ? 1 : 0;
    ef = (m_st == S_FAULT) ? 1 : 0;
    total++;
    if (int'(state_o) != es || int'(mmcm_rst_o) != er || int'(clk_ready_o) != ey ||
        int'(fault_o) != ef || int'(retry_cnt_o) != m_retry ||
        int'(lock_loss_cnt_o) != m_loss) begin
      bad++;
      $display("FAIL model: got st=%0d rst=%0d rdy=%0d flt=%0d rc=%0d loss=%0d expected st=%0d rst=%0d rdy=%0d flt=%0d rc=%0d loss=%0d at %0t",
               state_o, mmcm_rst_o, clk_ready_o, fault_o, retry_cnt_o, lock_loss_cnt_o,
               es, er, ey, ef, m_retry, m_loss, $time);
    end
  endtask

  task automatic wait_state(input string nm, input int want, input bit l, input int budget);
    int n;
    n = 0;
    while (int'(state_o) != want && n < budget) begin
      step(1'b0, 1'b0, l);
      n++;
    end
    check(nm, int'(state_o), want);
  endtask

  typedef struct {
    bit       rst;
    bit       sw;
    bit       lk;
    int       st;
    int       mrst;
    int       rdy;
    int       flt;
    int       rc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int hi, n, pulses, plen, badlen, maxr, saw_ready;
    bit prev, lk;

    // Reset, then plain ASSERT count-down into WAIT_LOCK.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].sw, vecs[i].lk);
      check($sformatf("vec%0d_state", i), int'(state_o), vecs[i].st);
      check($sformatf("vec%0d_outs", i),
            int'({mmcm_rst_o, clk_ready_o, fault_o, retry_cnt_o}),
            (vecs[i].mrst << 6) | (vecs[i].rdy << 5) | (vecs[i].flt << 4) | vecs[i].rc);
    end

    // Normal bring-up: lock arrives 10 cycles after release.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    hi = mmcm_rst_o ? 1 : 0;
    repeat (10) begin
      step(1'b0, 1'b0, 1'b0);
      if (mmcm_rst_o) hi++;
    end
    check("bringup_rst_len", hi, RC);
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end while (!clk_ready_o && n < 40);
    check("bringup_ready_latency", n, 2 + SC + 1);
    check("bringup_retry", int'(retry_cnt_o), 0);

    // Never lock: three reset pulses, then FAULT.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    pulses = 1; plen = 1; badlen = 0; maxr = 0; prev = 1'b1;
    for (int i = 0; i < 100 && !fault_o; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (mmcm_rst_o && !prev) begin
        pulses++;
        plen = 1;
        check("nolock_retry_at_pulse", int'(retry_cnt_o), pulses - 1);
      end else if (mmcm_rst_o) begin
        plen++;
      end else if (prev && plen != RC) begin
        badlen++;
      end
      prev = mmcm_rst_o;
      if (int'(retry_cnt_o) > maxr) maxr = int'(retry_cnt_o);
    end
    check("nolock_pulses", pulses, MR + 1);
    check("nolock_pulse_len_errors", badlen, 0);
    check("nolock_max_retry", maxr, MR);
    check("nolock_fault", int'(fault_o), 1);
    check("nolock_state", int'(state_o), S_FAULT);
    hi = 0;
    repeat (10) begin
      step(1'b0, 1'b0, 1'b0);
      if (mmcm_rst_o) hi++;
    end
    check("fault_rst_stays_low", hi, 0);
    check("fault_sticky", int'(fault_o), 1);

    // Software restart out of FAULT.
    step(1'b0, 1'b1, 1'b0);
    check("swfault_state", int'(state_o), S_ASSERT);
    check("swfault_fault", int'(fault_o), 0);
    check("swfault_retry", int'(retry_cnt_o), 0);

    // Lock glitch during SETTLE with retry_cnt=1.
    wait_state("glitch_to_wait", S_WAIT, 1'b0, 10);
    wait_state("glitch_timeout", S_ASSERT, 1'b0, 30);
    check("glitch_retry_pre", int'(retry_cnt_o), 1);
    wait_state("glitch_settle", S_SETTLE, 1'b1, 40);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    saw_ready = 0;
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0);
      if (clk_ready_o) saw_ready = 1;
    end
    check("glitch_state", int'(state_o), S_ASSERT);
    check("glitch_retry_kept", int'(retry_cnt_o), 1);
    check("glitch_no_ready", saw_ready, 0);

    // Repeated lock loss in READY: counter saturates, each loss re-pulses.
    wait_state("loss_ready0", S_READY, 1'b1, 60);
    for (int k = 0; k < 257; k++) begin
      n = 0;
      while (int'(state_o) == S_READY && n < 6) begin
        step(1'b0, 1'b0, 1'b0);
        n++;
      end
      check("loss_exit", int'(state_o), S_ASSERT);
      check("loss_count", int'(lock_loss_cnt_o), (k + 1 > 255) ? 255 : k + 1);
      plen = 1;
      while (mmcm_rst_o && plen < 10) begin
        step(1'b0, 1'b0, 1'b1);
        if (mmcm_rst_o) plen++;
      end
      check("loss_pulse_len", plen, RC);
      wait_state("loss_ready", S_READY, 1'b1, 40);
    end

    // Reset during WAIT_LOCK count 7.
    wait_state("rst_mid_assert", S_ASSERT, 1'b0, 6);
    wait_state("rst_mid_wait", S_WAIT, 1'b0, 10);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    check("rst_mid_pre_state", int'(state_o), S_WAIT);
    step(1'b1, 1'b1, 1'b0);
    check("rst_mid_state", int'(state_o), S_ASSERT);
    check("rst_mid_outs", int'({mmcm_rst_o, clk_ready_o, fault_o}), 3'b100);
    check("rst_mid_retry", int'(retry_cnt_o), 0);
    check("rst_mid_loss", int'(lock_loss_cnt_o), 0);
    wait_state("rst_mid_ready", S_READY, 1'b1, 40);
    check("rst_mid_ready_retry", int'(retry_cnt_o), 0);

    // Software restart coincident with a lock loss in READY.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("swloss_pre_state", int'(state_o), S_READY);
    step(1'b0, 1'b1, 1'b0);
    check("swloss_state", int'(state_o), S_ASSERT);
    check("swloss_loss", int'(lock_loss_cnt_o), 1);
    step(1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    lk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 199) == 0), lk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
